// File: rtl/mem_access_stage_if.sv
// Signal bundle for the memory-access stage: pipeline-side inputs, the data-memory
// req/ack bus and the stage results. The stage uses the master modport.
interface mem_access_stage_if;
  logic        mem_read;
  logic        mem_write;
  logic        byte_op;
  logic        half_op;
  logic        load_extended;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] read_data;
  logic        stall;
  logic        align_err;
  logic        bus_err;

  modport master (
    input  mem_read, mem_write, byte_op, half_op, load_extended,
    input  address, write_data, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
    output read_data, stall, align_err, bus_err
  );

  modport slave (
    output mem_read, mem_write, byte_op, half_op, load_extended,
    output address, write_data, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_byte_en, mem_wdata,
    input  read_data, stall, align_err, bus_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: one load/store per instruction over a variable-latency
// req/ack data memory, with pipeline stall, misalignment and bus-timeout reporting.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              rst,
  mem_access_stage_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       lane;
  logic             is_byte;
  logic             is_half;
  logic             is_load;
  logic             extend;

  logic             request;
  logic             misaligned;
  logic [3:0]       byte_en;
  logic [31:0]      wdata;
  logic [7:0]       byte_val;
  logic [15:0]      half_val;
  logic [31:0]      load_data;

  assign request = bus.mem_read | bus.mem_write;

  // Lane enables and replicated store data for the access presented in IDLE.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    wdata      = bus.write_data;
    if (bus.byte_op) begin
      wdata = {4{bus.write_data[7:0]}};
      if (!bus.mem_read) byte_en = 4'b0001 << bus.address[1:0];
    end else if (bus.half_op) begin
      misaligned = bus.address[0];
      wdata      = {2{bus.write_data[15:0]}};
      if (!bus.mem_read) byte_en = bus.address[1] ? 4'b1100 : 4'b0011;
    end else begin
      misaligned = (bus.address[1:0] != 2'b00);
    end
  end

  // Lane extraction uses the latched width/lane so inputs may change while BUSY.
  always_comb begin
    byte_val  = bus.mem_rdata[{lane, 3'b000} +: 8];
    half_val  = bus.mem_rdata[{lane[1], 4'b0000} +: 16];
    load_data = bus.mem_rdata;
    if (is_byte)
      load_data = {{24{extend & byte_val[7]}}, byte_val};
    else if (is_half)
      load_data = {{16{extend & half_val[15]}}, half_val};
  end

  // Reset forces Stall low even if an aligned request is sitting on the inputs.
  assign bus.stall = !rst && ((state == BUSY) ||
                              (state == IDLE && request && !misaligned));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      lane            <= 2'b00;
      is_byte         <= 1'b0;
      is_half         <= 1'b0;
      is_load         <= 1'b0;
      extend          <= 1'b0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_byte_en <= '0;
      bus.mem_wdata   <= '0;
      bus.read_data   <= '0;
      bus.align_err   <= 1'b0;
      bus.bus_err     <= 1'b0;
    end else begin
      bus.align_err <= 1'b0;
      bus.bus_err   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (request && misaligned) begin
            bus.align_err <= 1'b1;
            bus.read_data <= '0;
          end else if (request) begin
            bus.mem_addr    <= {bus.address[31:2], 2'b00};
            bus.mem_we      <= bus.mem_write & ~bus.mem_read;
            bus.mem_byte_en <= byte_en;
            bus.mem_wdata   <= wdata;
            lane            <= bus.address[1:0];
            is_byte         <= bus.byte_op;
            is_half         <= bus.half_op & ~bus.byte_op;
            is_load         <= bus.mem_read;
            extend          <= bus.load_extended;
            bus.mem_req     <= 1'b1;
            count           <= '0;
            state           <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (is_load) bus.read_data <= load_data;
            state <= DONE;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            bus.mem_req   <= 1'b0;
            bus.bus_err   <= 1'b1;
            bus.read_data <= '0;
            state         <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
